// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage register.
// The optional skid buffer is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // addi x0,x0,0: harmless instruction shown on an empty stage
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module pipe_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter int unsigned        CTRL_W   = CTRL_W_DEF,
  parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(RV_NOP),
  parameter int unsigned        CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic take_in;
  logic take_out;

  assign take_in  = in_valid & in_ready;
  assign take_out = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  skid_state_e       state;
  skid_state_e       state_nxt;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic [DATA_W-1:0] main_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_nxt;

  // State and payload registers; valid/ready are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_ctrl  <= '0;
      out_data  <= NOP_DATA;
      skid_ctrl <= '0;
      skid_data <= NOP_DATA;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != TWO);
      out_ctrl  <= main_ctrl_nxt;
      out_data  <= main_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      skid_data <= skid_data_nxt;
    end
  end

  // Next-state and payload steering
  always_comb begin
    state_nxt     = state;
    main_ctrl_nxt = out_ctrl;
    main_data_nxt = out_data;
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;
    if (flush) begin
      state_nxt     = EMPTY;
      main_ctrl_nxt = '0;
      main_data_nxt = NOP_DATA;
      skid_ctrl_nxt = '0;
      skid_data_nxt = NOP_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (take_in) begin
            state_nxt     = ONE;
            main_ctrl_nxt = in_ctrl;
            main_data_nxt = in_data;
          end
        end
        ONE: begin
          if (take_in && take_out) begin
            main_ctrl_nxt = in_ctrl;
            main_data_nxt = in_data;
          end else if (take_in) begin
            state_nxt     = TWO;
            skid_ctrl_nxt = in_ctrl;
            skid_data_nxt = in_data;
          end else if (take_out) begin
            state_nxt     = EMPTY;
            main_ctrl_nxt = '0;
            main_data_nxt = NOP_DATA;
          end
        end
        TWO: begin
          if (take_out) begin
            state_nxt     = ONE;
            main_ctrl_nxt = skid_ctrl;
            main_data_nxt = skid_data;
            skid_ctrl_nxt = '0;
            skid_data_nxt = NOP_DATA;
          end
        end
        default: begin
          state_nxt     = EMPTY;
          main_ctrl_nxt = '0;
          main_data_nxt = NOP_DATA;
          skid_ctrl_nxt = '0;
          skid_data_nxt = NOP_DATA;
        end
      endcase
    end
  end
`else
  assign in_ready = !out_valid | out_ready;

  // Single holding register; simultaneous in/out simply reloads it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= NOP_DATA;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= NOP_DATA;
    end else if (take_in) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (take_out) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= NOP_DATA;
    end
  end
`endif

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!out_valid && out_ready),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model of held beats.
// Build expectations follow PIPE_STAGE_SKID_EN (stage capacity 2 vs 1).
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [8:0]  c;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_ctrl;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_ctrl;
  logic [31:0] out_data;
  logic [15:0] bubble_cnt;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  beat_t       q[$];
  int unsigned m_bub = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Holding capacity decides acceptance: base accepts when empty or draining
  function automatic logic model_ready(input logic rdy);
    if (SKID) return (q.size() < 2);
    return (q.size() == 0) || rdy;
  endfunction

  // One clock: drive at negedge, check pre-edge state, update model at posedge
  task automatic tick(input logic v, input logic rdy, input logic fl,
                      input logic [8:0] c, input logic [31:0] d);
    logic  exp_rdy;
    logic  xin;
    logic  xout;
    beat_t b;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    in_ctrl   = c;
    in_data   = d;
    #1;
    exp_rdy = model_ready(rdy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      b = q[0];
      chk("out_ctrl", 64'(out_ctrl), 64'(b.c));
      chk("out_data", 64'(out_data), 64'(b.d));
    end else begin
      chk("idle_ctrl", 64'(out_ctrl), 64'(0));
      chk("idle_data", 64'(out_data), 64'h13);
    end
    xin  = v && exp_rdy;
    xout = (q.size() != 0) && rdy;
    if ((q.size() == 0) && rdy && (m_bub < 65535)) m_bub++;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back(beat_t'{c: c, d: d});
    end
    @(negedge clk);
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_ctrl = '0; in_data = '0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'h13);
    chk("rst_ctrl", 64'(out_ctrl), 64'(0));
    chk("rst_bub", 64'(bubble_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate
    tick(1'b1, 1'b1, 1'b0, 9'h011, 32'h100);
    chk("stream0", 64'(out_data), 64'h100);
    tick(1'b1, 1'b1, 1'b0, 9'h022, 32'h104);
    chk("stream1", 64'(out_data), 64'h104);
    tick(1'b1, 1'b1, 1'b0, 9'h033, 32'h108);
    chk("stream2", 64'(out_data), 64'h108);
    tick(1'b0, 1'b1, 1'b0, 9'h1FF, 32'hDEAD);
    chk("stream_bub", 64'(bubble_cnt), 64'(m_bub));

    // Backpressure for three cycles
    tick(1'b1, 1'b0, 1'b0, 9'h001, 32'h100);
    tick(1'b1, 1'b0, 1'b0, 9'h002, 32'h104);
    tick(1'b1, 1'b0, 1'b0, 9'h003, 32'h108);
    chk("bp_head", 64'(out_data), 64'h100);
    #1;
    chk("bp_ready", 64'(in_ready), 64'(0));
    chk("bp_held", 64'(q.size()), SKID ? 64'(2) : 64'(1));

    // Flush while full and offering another beat
    tick(1'b1, 1'b0, 1'b1, 9'h004, 32'h10C);
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_data", 64'(out_data), 64'h13);
    chk("fl_ctrl", 64'(out_ctrl), 64'(0));
    tick(1'b0, 1'b1, 1'b0, 9'h0AA, 32'h5555);
    chk("fl_noreplay", 64'(out_valid), 64'(0));

    // Async reset mid-stream with a held beat
    tick(1'b1, 1'b0, 1'b0, 9'h077, 32'h200);
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_data", 64'(out_data), 64'h13);
    chk("arst_bub", 64'(bubble_cnt), 64'(0));
    q.delete();
    m_bub = 0;
    @(negedge clk);
    rst = 1'b0;

    // Counter saturation with idle pipeline and ready downstream
    for (int i = 0; i < 70000; i++) tick(1'b0, 1'b1, 1'b0, 9'(i), 32'(i));
    chk("sat", 64'(bubble_cnt), 64'hFFFF);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 9'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
